// File: rtl/lstm_sequence_scheduler.sv
// Feeds buffered input samples to a multi-layer LSTM one at a time, loads the
// layers' C/h state at every sequence start and returns results downstream.
`timescale 1ns/1ps
module lstm_sequence_scheduler #(
    parameter int unsigned LAYERS     = 4,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  s_x_data,
    input  logic              s_x_last,
    input  logic              s_x_valid,
    output logic              s_x_ready,
    output logic [WIDTH-1:0]  state_data,
    output logic [LAYERS-1:0] c_in_valid,
    output logic [LAYERS-1:0] h_in_valid,
    output logic [WIDTH-1:0]  x_in,
    output logic              x_in_valid,
    input  logic              lstm_ready,
    input  logic [WIDTH-1:0]  lstm_y,
    input  logic              lstm_valid,
    output logic [WIDTH-1:0]  m_y_data,
    output logic              m_y_last,
    output logic              m_y_valid,
    input  logic              m_y_ready,
    output logic              busy,
    output logic [15:0]       seq_done,
    output logic              timeout_err,
    output logic              spurious_err
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WAIT_RDY,
        ISSUE,
        WAIT_OUT,
        HOLD
    } state_t;

    state_t          state;
    logic            init_pending;
    logic            last_q;
    logic [TW-1:0]   tmo_cnt;

    logic [WIDTH:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic [WIDTH:0]  head;

    assign fifo_empty = (count == '0);
    assign s_x_ready  = (count != CW'(FIFO_DEPTH));
    assign push       = s_x_valid && s_x_ready;
    assign pop        = (state == ISSUE);
    assign head       = mem[rd_ptr];
    assign busy       = (state != IDLE) || !fifo_empty;
    assign state_data = '0;

    // Sample storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_x_last, s_x_data};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sequencing FSM with registered strobes and result channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            init_pending <= 1'b1;
            last_q       <= 1'b0;
            tmo_cnt      <= '0;
            c_in_valid   <= '0;
            h_in_valid   <= '0;
            x_in         <= '0;
            x_in_valid   <= 1'b0;
            m_y_data     <= '0;
            m_y_last     <= 1'b0;
            m_y_valid    <= 1'b0;
            seq_done     <= '0;
            timeout_err  <= 1'b0;
            spurious_err <= 1'b0;
        end else begin
            if (lstm_valid && (state != WAIT_OUT)) begin
                spurious_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (init_pending) begin
                            c_in_valid <= LAYERS'(1);
                            h_in_valid <= LAYERS'(1);
                            state      <= INIT;
                        end else begin
                            state <= WAIT_RDY;
                        end
                    end
                end
                INIT: begin
                    // One layer per cycle; the top bit marks the final layer.
                    if (c_in_valid[LAYERS-1]) begin
                        c_in_valid   <= '0;
                        h_in_valid   <= '0;
                        init_pending <= 1'b0;
                        state        <= WAIT_RDY;
                    end else begin
                        c_in_valid <= c_in_valid << 1;
                        h_in_valid <= h_in_valid << 1;
                    end
                end
                WAIT_RDY: begin
                    if (lstm_ready) begin
                        x_in       <= head[WIDTH-1:0];
                        last_q     <= head[WIDTH];
                        x_in_valid <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    x_in_valid <= 1'b0;
                    tmo_cnt    <= '0;
                    state      <= WAIT_OUT;
                end
                WAIT_OUT: begin
                    if (lstm_valid) begin
                        m_y_data  <= lstm_y;
                        m_y_last  <= last_q;
                        m_y_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        // Lost result: the LSTM state is suspect, so re-initialise.
                        timeout_err  <= 1'b1;
                        init_pending <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                HOLD: begin
                    if (m_y_ready) begin
                        m_y_valid <= 1'b0;
                        if (m_y_last) begin
                            seq_done     <= seq_done + 16'd1;
                            init_pending <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_sequence_scheduler.sv
// Self-checking bench for lstm_sequence_scheduler: directed cycle table,
// corner-case sequences and a randomized run against a transaction model.
`timescale 1ns/1ps
module tb_lstm_sequence_scheduler;

    localparam int unsigned LAYERS = 4;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned TMO    = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic [WIDTH-1:0]  s_x_data;
    logic              s_x_last;
    logic              s_x_valid;
    logic              s_x_ready;
    logic [WIDTH-1:0]  state_data;
    logic [LAYERS-1:0] c_in_valid;
    logic [LAYERS-1:0] h_in_valid;
    logic [WIDTH-1:0]  x_in;
    logic              x_in_valid;
    logic              lstm_ready;
    logic [WIDTH-1:0]  lstm_y;
    logic              lstm_valid;
    logic [WIDTH-1:0]  m_y_data;
    logic              m_y_last;
    logic              m_y_valid;
    logic              m_y_ready;
    logic              busy;
    logic [15:0]       seq_done;
    logic              timeout_err;
    logic              spurious_err;

    lstm_sequence_scheduler #(
        .LAYERS(LAYERS), .WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_x_data(s_x_data), .s_x_last(s_x_last), .s_x_valid(s_x_valid), .s_x_ready(s_x_ready),
        .state_data(state_data), .c_in_valid(c_in_valid), .h_in_valid(h_in_valid),
        .x_in(x_in), .x_in_valid(x_in_valid), .lstm_ready(lstm_ready),
        .lstm_y(lstm_y), .lstm_valid(lstm_valid),
        .m_y_data(m_y_data), .m_y_last(m_y_last), .m_y_valid(m_y_valid), .m_y_ready(m_y_ready),
        .busy(busy), .seq_done(seq_done), .timeout_err(timeout_err), .spurious_err(spurious_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sv;
        logic [15:0] sd;
        logic        sl;
        logic        lv;
        logic [15:0] ly;
        logic [3:0]  c;
        logic        xv;
        logic [15:0] xin;
        logic        myv;
        logic [15:0] myd;
        logic        myl;
        logic [15:0] seq;
        logic        bsy;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic sv, input logic [15:0] sd, input logic sl,
                                input logic lv, input logic [15:0] ly, input logic [3:0] c,
                                input logic xv, input logic [15:0] xin, input logic myv,
                                input logic [15:0] myd, input logic myl,
                                input logic [15:0] seq, input logic bsy);
        vec_t v;
        v.sv = sv; v.sd = sd; v.sl = sl; v.lv = lv; v.ly = ly; v.c = c; v.xv = xv;
        v.xin = xin; v.myv = myv; v.myd = myd; v.myl = myl; v.seq = seq; v.bsy = bsy;
        return v;
    endfunction

    // Stand-in for the LSTM datapath: any fixed function of x will do.
    function automatic logic [15:0] f_lstm(input logic [15:0] x);
        return x * 16'd3 + 16'd1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_x_valid = 1'b0; s_x_data = '0; s_x_last = 1'b0;
        lstm_ready = 1'b0; lstm_y = '0; lstm_valid = 1'b0; m_y_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
    endtask

    task automatic push(input logic [15:0] d, input logic l);
        int n = 0;
        s_x_valid = 1'b1; s_x_data = d; s_x_last = l;
        while (!s_x_ready && n < 50) begin
            step();
            n++;
        end
        chk("push_ready", 32'(s_x_ready), 32'd1);
        step();
        s_x_valid = 1'b0;
    endtask

    task automatic wait_xv(input int lim);
        int n = 0;
        while (!x_in_valid && n < lim) begin
            step();
            n++;
        end
        chk("wait_x_in_valid", 32'(x_in_valid), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int          accepted;
        logic        acc_now;
        int          n;
        logic [3:0]  seen[$];
        logic [16:0] exp_q[$];
        logic [16:0] hd;
        logic [3:0]  strobes[$];
        logic        need_init, outstanding, out_l, pend, prev_hold, l_tmp;
        logic [15:0] out_x, prev_d, model_seq, d_tmp;
        int          wait_c;

        rst = 1'b1;
        idle_inputs();

        // Reset values.
        do_reset();
        chk("rst_s_x_ready", 32'(s_x_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_c_in_valid", 32'(c_in_valid), 32'd0);
        chk("rst_h_in_valid", 32'(h_in_valid), 32'd0);
        chk("rst_x_in_valid", 32'(x_in_valid), 32'd0);
        chk("rst_x_in", 32'(x_in), 32'd0);
        chk("rst_m_y_valid", 32'(m_y_valid), 32'd0);
        chk("rst_m_y_data", 32'(m_y_data), 32'd0);
        chk("rst_m_y_last", 32'(m_y_last), 32'd0);
        chk("rst_seq_done", 32'(seq_done), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_spurious_err", 32'(spurious_err), 32'd0);
        chk("rst_state_data", 32'(state_data), 32'd0);

        // Two-sample sequence, cycle by cycle; LSTM answers 3 cycles after x.
        //             sv  sd        sl lv ly        c     xv xin       myv myd       myl seq  busy
        tbl[0]  = mk(1, 16'h0100, 0, 0, 16'h0000, 4'h0, 0, 16'h0000, 0, 16'h0000, 0, 16'd0, 1);
        tbl[1]  = mk(1, 16'h0200, 1, 0, 16'h0000, 4'h1, 0, 16'h0000, 0, 16'h0000, 0, 16'd0, 1);
        tbl[2]  = mk(0, 16'h0000, 0, 0, 16'h0000, 4'h2, 0, 16'h0000, 0, 16'h0000, 0, 16'd0, 1);
        tbl[3]  = mk(0, 16'h0000, 0, 0, 16'h0000, 4'h4, 0, 16'h0000, 0, 16'h0000, 0, 16'd0, 1);
        tbl[4]  = mk(0, 16'h0000, 0, 0, 16'h0000, 4'h8, 0, 16'h0000, 0, 16'h0000, 0, 16'd0, 1);
        tbl[5]  = mk(0, 16'h0000, 0, 0, 16'h0000, 4'h0, 0, 16'h0000, 0, 16'h0000, 0, 16'd0, 1);
        tbl[6]  = mk(0, 16'h0000, 0, 0, 16'h0000, 4'h0, 1, 16'h0100, 0, 16'h0000, 0, 16'd0, 1);
        tbl[7]  = mk(0, 16'h0000, 0, 0, 16'h0000, 4'h0, 0, 16'h0100, 0, 16'h0000, 0, 16'd0, 1);
        tbl[8]  = mk(0, 16'h0000, 0, 0, 16'h0000, 4'h0, 0, 16'h0100, 0, 16'h0000, 0, 16'd0, 1);
        tbl[9]  = mk(0, 16'h0000, 0, 0, 16'h0000, 4'h0, 0, 16'h0100, 0, 16'h0000, 0, 16'd0, 1);
        tbl[10] = mk(0, 16'h0000, 0, 1, 16'h1111, 4'h0, 0, 16'h0100, 1, 16'h1111, 0, 16'd0, 1);
        tbl[11] = mk(0, 16'h0000, 0, 0, 16'h0000, 4'h0, 0, 16'h0100, 0, 16'h1111, 0, 16'd0, 1);
        tbl[12] = mk(0, 16'h0000, 0, 0, 16'h0000, 4'h0, 0, 16'h0100, 0, 16'h1111, 0, 16'd0, 1);
        tbl[13] = mk(0, 16'h0000, 0, 0, 16'h0000, 4'h0, 1, 16'h0200, 0, 16'h1111, 0, 16'd0, 1);
        tbl[14] = mk(0, 16'h0000, 0, 0, 16'h0000, 4'h0, 0, 16'h0200, 0, 16'h1111, 0, 16'd0, 1);
        tbl[15] = mk(0, 16'h0000, 0, 0, 16'h0000, 4'h0, 0, 16'h0200, 0, 16'h1111, 0, 16'd0, 1);
        tbl[16] = mk(0, 16'h0000, 0, 0, 16'h0000, 4'h0, 0, 16'h0200, 0, 16'h1111, 0, 16'd0, 1);
        tbl[17] = mk(0, 16'h0000, 0, 1, 16'h2222, 4'h0, 0, 16'h0200, 1, 16'h2222, 1, 16'd0, 1);
        tbl[18] = mk(0, 16'h0000, 0, 0, 16'h0000, 4'h0, 0, 16'h0200, 0, 16'h2222, 1, 16'd1, 0);
        tbl[19] = mk(0, 16'h0000, 0, 0, 16'h0000, 4'h0, 0, 16'h0200, 0, 16'h2222, 1, 16'd1, 0);

        lstm_ready = 1'b1;
        m_y_ready  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_x_valid = tbl[i].sv; s_x_data = tbl[i].sd; s_x_last = tbl[i].sl;
            lstm_valid = tbl[i].lv; lstm_y = tbl[i].ly;
            step();
            chk($sformatf("v%0d_c_in_valid", i), 32'(c_in_valid), 32'(tbl[i].c));
            chk($sformatf("v%0d_h_in_valid", i), 32'(h_in_valid), 32'(tbl[i].c));
            chk($sformatf("v%0d_x_in_valid", i), 32'(x_in_valid), 32'(tbl[i].xv));
            chk($sformatf("v%0d_x_in", i), 32'(x_in), 32'(tbl[i].xin));
            chk($sformatf("v%0d_m_y_valid", i), 32'(m_y_valid), 32'(tbl[i].myv));
            chk($sformatf("v%0d_m_y_data", i), 32'(m_y_data), 32'(tbl[i].myd));
            chk($sformatf("v%0d_m_y_last", i), 32'(m_y_last), 32'(tbl[i].myl));
            chk($sformatf("v%0d_seq_done", i), 32'(seq_done), 32'(tbl[i].seq));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
        end

        // FIFO fill: 16 accepted with the LSTM stalled, 17th waits for the first pop.
        do_reset();
        lstm_ready = 1'b0;
        m_y_ready  = 1'b1;
        accepted   = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            s_x_valid = 1'b1;
            s_x_data  = 16'h3000 + 16'(accepted);
            acc_now   = s_x_ready;
            step();
            if (acc_now) accepted++;
        end
        chk("full_accepted", 32'(accepted), 32'd16);
        chk("full_ready_low", 32'(s_x_ready), 32'd0);
        lstm_ready = 1'b1;
        wait_xv(20);
        chk("full_ready_at_issue", 32'(s_x_ready), 32'd0);
        chk("full_first_x", 32'(x_in), 32'h3000);
        lstm_ready = 1'b0;
        step();
        chk("full_ready_after_pop", 32'(s_x_ready), 32'd1);
        step();
        chk("full_17th_taken", 32'(s_x_ready), 32'd0);
        s_x_valid = 1'b0;

        // Result backpressure for 10 cycles holds data and blocks the next issue.
        do_reset();
        push(16'h4000, 1'b0);
        push(16'h4001, 1'b1);
        lstm_ready = 1'b1;
        m_y_ready  = 1'b0;
        wait_xv(20);
        step();
        lstm_valid = 1'b1; lstm_y = 16'hBEEF;
        step();
        lstm_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp%0d_m_y_valid", i), 32'(m_y_valid), 32'd1);
            chk($sformatf("bp%0d_m_y_data", i), 32'(m_y_data), 32'hBEEF);
            chk($sformatf("bp%0d_no_issue", i), 32'(x_in_valid), 32'd0);
            step();
        end
        m_y_ready = 1'b1;
        step();
        chk("bp_valid_drop", 32'(m_y_valid), 32'd0);
        wait_xv(20);
        chk("bp_second_x", 32'(x_in), 32'h4001);

        // LSTM never answers: timeout after TMO waiting cycles, then re-init.
        do_reset();
        push(16'h5000, 1'b0);
        push(16'h5001, 1'b0);
        lstm_ready = 1'b1;
        m_y_ready  = 1'b1;
        wait_xv(20);
        n = 0;
        while (!timeout_err && n < 1100) begin
            step();
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'(TMO + 1));
        chk("tmo_no_result", 32'(m_y_valid), 32'd0);
        seen.delete();
        n = 0;
        do begin
            step();
            n++;
            if (c_in_valid != 0) seen.push_back(c_in_valid);
        end while (!x_in_valid && n < 30);
        chk("tmo_reinit_len", 32'(seen.size()), 32'd4);
        for (int i = 0; i < seen.size() && i < 4; i++)
            chk($sformatf("tmo_reinit_%0d", i), 32'(seen[i]), 32'(4'b0001 << i));
        chk("tmo_next_x", 32'(x_in), 32'h5001);
        chk("tmo_sticky", 32'(timeout_err), 32'd1);

        // Spurious LSTM result while idle.
        do_reset();
        lstm_valid = 1'b1; lstm_y = 16'hDEAD;
        step();
        lstm_valid = 1'b0;
        chk("spur_flag", 32'(spurious_err), 32'd1);
        chk("spur_no_result", 32'(m_y_valid), 32'd0);
        step();
        chk("spur_sticky", 32'(spurious_err), 32'd1);
        chk("spur_no_result2", 32'(m_y_valid), 32'd0);

        // Reset during the second INIT cycle.
        do_reset();
        push(16'h6000, 1'b1);
        n = 0;
        while (c_in_valid != 4'b0010 && n < 20) begin
            step();
            n++;
        end
        chk("rinit_reached", 32'(c_in_valid), 32'h2);
        rst = 1'b1;
        step();
        chk("rinit_c", 32'(c_in_valid), 32'd0);
        chk("rinit_h", 32'(h_in_valid), 32'd0);
        chk("rinit_xv", 32'(x_in_valid), 32'd0);
        chk("rinit_busy", 32'(busy), 32'd0);
        chk("rinit_ready", 32'(s_x_ready), 32'd1);
        rst = 1'b0;

        // Randomized traffic against a transaction-level model.
        do_reset();
        exp_q.delete(); strobes.delete();
        need_init = 1'b1; outstanding = 1'b0; pend = 1'b0; prev_hold = 1'b0;
        out_x = '0; out_l = 1'b0; prev_d = '0; model_seq = '0; wait_c = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (c_in_valid != 0 || h_in_valid != 0) begin
                chk("rnd_c_eq_h", 32'(h_in_valid), 32'(c_in_valid));
                strobes.push_back(c_in_valid);
            end
            if (x_in_valid) begin
                chk("rnd_one_in_flight", 32'(outstanding), 32'd0);
                chk("rnd_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    hd = exp_q.pop_front();
                    chk("rnd_x_in", 32'(x_in), 32'(hd[15:0]));
                    out_x = hd[15:0];
                    out_l = hd[16];
                end
                chk("rnd_init_len", 32'(strobes.size()), need_init ? 32'd4 : 32'd0);
                if (need_init && strobes.size() == 4)
                    for (int i = 0; i < 4; i++)
                        chk("rnd_init_order", 32'(strobes[i]), 32'(4'b0001 << i));
                strobes.delete();
                need_init   = 1'b0;
                outstanding = 1'b1;
                pend        = 1'b1;
                wait_c      = $urandom_range(1, 6);
            end
            if (prev_hold) begin
                chk("rnd_hold_valid", 32'(m_y_valid), 32'd1);
                chk("rnd_hold_data", 32'(m_y_data), 32'(prev_d));
            end
            if (m_y_valid) chk("rnd_result_owner", 32'(outstanding), 32'd1);
            chk("rnd_seq_done", 32'(seq_done), 32'(model_seq));

            lstm_valid = 1'b0;
            if (pend) begin
                if (wait_c == 0) begin
                    lstm_valid = 1'b1;
                    lstm_y     = f_lstm(out_x);
                    pend       = 1'b0;
                end else begin
                    wait_c--;
                end
            end
            lstm_ready = ($urandom_range(0, 3) != 0);
            m_y_ready  = ($urandom_range(0, 1) != 0);
            if (m_y_valid && m_y_ready) begin
                chk("rnd_y_data", 32'(m_y_data), 32'(f_lstm(out_x)));
                chk("rnd_y_last", 32'(m_y_last), 32'(out_l));
                outstanding = 1'b0;
                if (out_l) begin
                    model_seq = model_seq + 16'd1;
                    need_init = 1'b1;
                end
            end
            prev_hold = m_y_valid && !m_y_ready;
            prev_d    = m_y_data;
            d_tmp     = 16'($urandom);
            l_tmp     = ($urandom_range(0, 3) == 0);
            s_x_valid = (cyc < 3000) && ($urandom_range(0, 1) != 0);
            s_x_data  = d_tmp;
            s_x_last  = l_tmp;
            if (s_x_valid && s_x_ready) exp_q.push_back({l_tmp, d_tmp});
            step();
        end
        chk("rnd_drained", 32'(exp_q.size()), 32'd0);
        chk("rnd_no_outstanding", 32'(outstanding), 32'd0);
        chk("rnd_idle", 32'(busy), 32'd0);
        chk("rnd_no_timeout", 32'(timeout_err), 32'd0);
        chk("rnd_no_spurious", 32'(spurious_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
